vid_sync_meas: RTL and testbench

//  Downstream monitor for the trigger-driven timing generator: consumes its hsync/vsync/daten outputs.

---
 rtl/vid_sync_meas.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_vid_sync_meas.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vid_sync_meas.sv
// vid_sync_meas: monitor for a trigger-driven timing generator.
// Measures hsync width, line period and active width in ena-qualified ticks,
// plus lines per frame and vsync width in lines. It raises locked once the
// line period has been stable for LOCK_LINES lines, and sets a sticky err
// when timing breaks while locked.
module vid_sync_meas #(
    parameter int CW         = 16,
    parameter int LW         = 12,
    parameter int LOCK_LINES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          daten,
    input  logic          clr_err,
    output logic [CW-1:0] meas_hsw,
    output logic [CW-1:0] meas_hlen,
    output logic [CW-1:0] meas_act,
    output logic [LW-1:0] meas_vsw,
    output logic [LW-1:0] meas_lines,
    output logic          line_stb,
    output logic          frame_stb,
    output logic          locked,
    output logic          err
);

    // Wide enough to hold LOCK_LINES + 1 without wrapping.
    localparam int MW = $clog2(LOCK_LINES + 2);

    localparam logic [CW-1:0] C_MAX  = {CW{1'b1}};
    localparam logic [LW-1:0] L_MAX  = {LW{1'b1}};
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [LW-1:0] L_ONE  = LW'(1);
    localparam logic [MW-1:0] M_ONE  = MW'(1);
    localparam logic [MW-1:0] M_LOCK = MW'(LOCK_LINES);

    typedef enum logic [0:0] {
        WAIT_H = 1'b0,
        LINE   = 1'b1
    } line_state_t;

    typedef enum logic [0:0] {
        F_WAIT = 1'b0,
        F_RUN  = 1'b1
    } frame_state_t;

    // Saturating increment in the pixel domain.
    function automatic logic [CW-1:0] f_sat_inc_c(input logic [CW-1:0] v);
        return (v == C_MAX) ? v : (v + C_ONE);
    endfunction

    // Saturating increment in the line domain.
    function automatic logic [LW-1:0] f_sat_inc_l(input logic [LW-1:0] v);
        return (v == L_MAX) ? v : (v + L_ONE);
    endfunction

    line_state_t  r_line_state;
    line_state_t  w_line_next;
    frame_state_t r_frame_state;
    frame_state_t w_frame_next;

    logic          r_hs_q;
    logic          r_vs_q;
    logic [CW-1:0] r_pcnt;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] r_acnt;
    logic [LW-1:0] r_lcnt;
    logic [LW-1:0] r_vcnt;
    logic [MW-1:0] r_match;
    logic          r_have_prev;

    logic          w_hrise;
    logic          w_hfall;
    logic          w_vrise;
    logic          w_vfall;
    logic          w_meas_line;
    logic          w_timeout;
    logic          w_meas_frame;
    logic          w_meas_vsw;
    logic          w_period_match;
    logic [MW-1:0] w_match_inc;
    logic          w_err_set;
    logic          w_err_clr;
    logic [CW-1:0] w_act_final;
    logic [LW-1:0] w_vsw_final;

    // Edges only exist on ena ticks; this gating freezes everything on idle cycles.
    assign w_hrise = ena &  hsync & ~r_hs_q;
    assign w_hfall = ena & ~hsync &  r_hs_q;
    assign w_vrise = ena &  vsync & ~r_vs_q;
    assign w_vfall = ena & ~vsync &  r_vs_q;

    // The tick that carries the rise still belongs to the line being closed.
    assign w_act_final = daten ? f_sat_inc_c(r_acnt) : r_acnt;
    assign w_vsw_final = w_hrise ? f_sat_inc_l(r_vcnt) : r_vcnt;

    // The first period after (re)acquisition has nothing to compare against.
    assign w_period_match = r_have_prev & (r_pcnt == meas_hlen);
    assign w_match_inc    = r_match + M_ONE;

    assign w_err_set = locked & (w_timeout | (w_meas_line & ~w_period_match));
    assign w_err_clr = ena & clr_err;

    // Input edge-detect history, sampled on ena ticks only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_q <= 1'b0;
            r_vs_q <= 1'b0;
        end else if (ena) begin
            r_hs_q <= hsync;
            r_vs_q <= vsync;
        end
    end

    // Pixel-domain counters: period, sync width and active ticks of the current line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= {CW{1'b0}};
            r_wcnt <= {CW{1'b0}};
            r_acnt <= {CW{1'b0}};
        end else if (ena) begin
            r_pcnt <= w_hrise ? C_ONE : f_sat_inc_c(r_pcnt);
            if (w_hrise) begin
                r_wcnt <= C_ONE;
            end else if (hsync) begin
                r_wcnt <= f_sat_inc_c(r_wcnt);
            end
            if (w_hrise) begin
                r_acnt <= {CW{1'b0}};
            end else if (daten) begin
                r_acnt <= f_sat_inc_c(r_acnt);
            end
        end
    end

    // Line-domain counters: lines since vsync rise and lines while vsync is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lcnt <= {LW{1'b0}};
            r_vcnt <= {LW{1'b0}};
        end else if (ena) begin
            if (w_vrise) begin
                r_lcnt <= w_hrise ? L_ONE : {LW{1'b0}};
            end else if (w_hrise) begin
                r_lcnt <= f_sat_inc_l(r_lcnt);
            end
            if (w_vrise) begin
                r_vcnt <= {LW{1'b0}};
            end else if (w_hrise && vsync) begin
                r_vcnt <= f_sat_inc_l(r_vcnt);
            end
        end
    end

    // Line FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_state <= WAIT_H;
        end else begin
            r_line_state <= w_line_next;
        end
    end

    // Line FSM next state: acquire on a rise, measure on later rises, drop on counter saturation.
    always_comb begin
        w_line_next = r_line_state;
        w_meas_line = 1'b0;
        w_timeout   = 1'b0;
        case (r_line_state)
            WAIT_H: begin
                if (w_hrise) begin
                    w_line_next = LINE;
                end else begin
                    w_line_next = WAIT_H;
                end
            end
            LINE: begin
                if (w_hrise) begin
                    w_meas_line = 1'b1;
                    w_line_next = LINE;
                end else if (ena && (r_pcnt == C_MAX)) begin
                    w_timeout   = 1'b1;
                    w_line_next = WAIT_H;
                end else begin
                    w_line_next = LINE;
                end
            end
            default: begin
                w_line_next = WAIT_H;
            end
        endcase
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_state <= F_WAIT;
        end else begin
            r_frame_state <= w_frame_next;
        end
    end

    // Frame FSM next state: the first vsync rise only arms measurement.
    always_comb begin
        w_frame_next = r_frame_state;
        w_meas_frame = 1'b0;
        w_meas_vsw   = 1'b0;
        case (r_frame_state)
            F_WAIT: begin
                if (w_vrise) begin
                    w_frame_next = F_RUN;
                end else begin
                    w_frame_next = F_WAIT;
                end
            end
            F_RUN: begin
                w_frame_next = F_RUN;
                w_meas_frame = w_vrise;
                w_meas_vsw   = w_vfall;
            end
            default: begin
                w_frame_next = F_WAIT;
            end
        endcase
    end

    // Result registers and one-clock strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_hsw   <= {CW{1'b0}};
            meas_hlen  <= {CW{1'b0}};
            meas_act   <= {CW{1'b0}};
            meas_vsw   <= {LW{1'b0}};
            meas_lines <= {LW{1'b0}};
            line_stb   <= 1'b0;
            frame_stb  <= 1'b0;
        end else begin
            line_stb  <= w_meas_line;
            frame_stb <= w_meas_frame;
            if (w_hfall) begin
                meas_hsw <= r_wcnt;
            end
            if (w_meas_line) begin
                meas_hlen <= r_pcnt;
                meas_act  <= w_act_final;
            end
            if (w_meas_frame) begin
                meas_lines <= r_lcnt;
            end
            if (w_meas_vsw) begin
                meas_vsw <= w_vsw_final;
            end
        end
    end

    // Lock tracking: count consecutive equal periods, drop lock on any break.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_match     <= {MW{1'b0}};
            r_have_prev <= 1'b0;
            locked      <= 1'b0;
        end else if (w_timeout) begin
            r_match     <= {MW{1'b0}};
            r_have_prev <= 1'b0;
            locked      <= 1'b0;
        end else if (w_meas_line) begin
            r_have_prev <= 1'b1;
            if (w_period_match) begin
                r_match <= (w_match_inc > M_LOCK) ? M_LOCK : w_match_inc;
                if (w_match_inc >= M_LOCK) begin
                    locked <= 1'b1;
                end
            end else begin
                r_match <= {MW{1'b0}};
                locked  <= 1'b0;
            end
        end
    end

    // Sticky error: a new break outranks a simultaneous clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (w_err_set) begin
            err <= 1'b1;
        end else if (w_err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vid_sync_meas.sv
// Bench for vid_sync_meas: drives whole video lines, predicts every measurement
// from the line parameters chosen (period, sync width, data window, vsync level).
module tb_vid_sync_meas;

    localparam int CW   = 16;
    localparam int LW   = 12;
    localparam int LOCK = 4;

    logic          clk = 1'b0;
    logic          rst, ena, hsync, vsync, daten, clr_err;
    logic [CW-1:0] meas_hsw, meas_hlen, meas_act;
    logic [LW-1:0] meas_vsw, meas_lines;
    logic          line_stb, frame_stb, locked, err;

    vid_sync_meas #(.CW(CW), .LW(LW), .LOCK_LINES(LOCK)) dut (
        .clk(clk), .rst(rst), .ena(ena), .hsync(hsync), .vsync(vsync),
        .daten(daten), .clr_err(clr_err), .meas_hsw(meas_hsw),
        .meas_hlen(meas_hlen), .meas_act(meas_act), .meas_vsw(meas_vsw),
        .meas_lines(meas_lines), .line_stb(line_stb), .frame_stb(frame_stb),
        .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Reference state, expressed in lines and frames rather than counters.
    bit m_inline, m_locked, m_err, m_frun, m_vs;
    int m_hlen, m_act, m_hsw, m_lines, m_vsw, m_lcnt, m_vlines, m_acc, m_plen;
    int q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_inline = 0; m_locked = 0; m_err = 0; m_frun = 0; m_vs = 0;
        m_hlen = 0; m_act = 0; m_hsw = 0; m_lines = 0; m_vsw = 0;
        m_lcnt = 0; m_vlines = 0; m_acc = 0; m_plen = 0;
        q.delete();
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_hlen"},   meas_hlen,  m_hlen);
        chk({tag, "_act"},    meas_act,   m_act);
        chk({tag, "_hsw"},    meas_hsw,   m_hsw);
        chk({tag, "_lines"},  meas_lines, m_lines);
        chk({tag, "_vsw"},    meas_vsw,   m_vsw);
        chk({tag, "_locked"}, locked,     m_locked);
        chk({tag, "_err"},    err,        m_err);
    endtask

    task automatic do_reset();
        rst = 1; ena = 1; hsync = 0; vsync = 0; daten = 0; clr_err = 0;
        cyc();
        rst = 0;
        model_reset();
        check_all("rst");
        chk("rst_line_stb", line_stb, 0);
        chk("rst_frame_stb", frame_stb, 0);
    endtask

    // One line: rise at tick 0, hsync high for w ticks, daten over [a0,a0+al),
    // vsync level v for the whole line, optional clr_err on the rise tick,
    // and gap idle (ena=0) cycles with random inputs after every tick.
    task automatic line(input int p, input int w, input int a0, input int al,
                        input bit v, input bit clr, input int gap);
        bit exp_lstb, exp_fstb, vrise, vfall, set, nl;
        int run;
        for (int t = 0; t < p; t++) begin
            ena = 1; hsync = (t < w); vsync = v;
            daten = (t >= a0) && (t < a0 + al);
            clr_err = (t == 0) ? clr : 1'b0;
            cyc();
            if (t == 0) begin
                exp_lstb = m_inline;
                set = 0;
                if (m_inline) begin
                    m_hlen = m_plen;
                    m_act  = m_acc + int'(daten);
                    q.push_back(m_hlen);
                    if (q.size() > 8) void'(q.pop_front());
                    run = 0;
                    for (int i = q.size() - 1; i >= 0; i--) begin
                        if (q[i] != q[q.size() - 1]) break;
                        run++;
                    end
                    nl = (run >= LOCK + 1);
                    set = m_locked && !nl;
                    m_locked = nl;
                end else begin
                    m_inline = 1;
                    q.delete();
                end
                if (set) m_err = 1;
                else if (clr) m_err = 0;
                vrise = v && !m_vs;
                vfall = !v && m_vs;
                exp_fstb = 0;
                if (vrise) begin
                    if (m_frun) begin
                        exp_fstb = 1;
                        m_lines = m_lcnt;
                    end
                    m_frun = 1; m_lcnt = 1; m_vlines = 1;
                end else begin
                    m_lcnt = (m_lcnt >= 4095) ? 4095 : m_lcnt + 1;
                    if (v) m_vlines++;
                end
                if (vfall && m_frun) m_vsw = m_vlines;
                m_vs = v;
                chk("rise_line_stb", line_stb, exp_lstb);
                chk("rise_frame_stb", frame_stb, exp_fstb);
                check_all("rise");
                m_acc = 0;
            end else begin
                if (daten) m_acc++;
                if (t == 1) begin
                    chk("stb_one_clk_line", line_stb, 0);
                    chk("stb_one_clk_frame", frame_stb, 0);
                end
            end
            if (t == w) m_hsw = w;
            for (int g = 0; g < gap; g++) begin
                ena = 0; clr_err = 0;
                hsync = 1'($urandom); vsync = 1'($urandom); daten = 1'($urandom);
                cyc();
                chk("idle_line_stb", line_stb, 0);
                chk("idle_frame_stb", frame_stb, 0);
                chk("idle_hlen", meas_hlen, m_hlen);
                chk("idle_locked", locked, m_locked);
            end
        end
        m_plen = p;
        if (m_inline && p >= 65536) begin
            if (m_locked) m_err = 1;
            m_locked = 0;
            m_inline = 0;
            chk("timeout_locked", locked, m_locked);
            chk("timeout_err", err, m_err);
        end
    endtask

    initial begin
        int base, p, w, a0;
        rst = 1; ena = 0; hsync = 0; vsync = 0; daten = 0; clr_err = 0;
        repeat (3) cyc();
        do_reset();

        // Steady 100-tick lines, width 8, no data: lock forms at the sixth rise.
        for (int i = 0; i < 7; i++) line(100, 8, 0, 0, 1'b0, 1'b0, 0);
        chk("t1_hlen", meas_hlen, 100);
        chk("t1_hsw", meas_hsw, 8);
        chk("t1_act", meas_act, 0);
        chk("t2_locked", locked, 1);
        // A 99-tick line breaks lock; clearing afterwards drops err.
        line(99, 8, 0, 0, 1'b0, 1'b0, 0);
        line(100, 8, 0, 0, 1'b0, 1'b0, 0);
        chk("t2_unlock", locked, 0);
        chk("t2_err", err, 1);
        line(100, 8, 0, 0, 1'b0, 1'b1, 0);
        chk("t2_clr", err, 0);

        // ena toggling 1:1: 200 clk per line still measures 100 ticks.
        for (int i = 0; i < 3; i++) line(100, 10, 20, 50, 1'b0, 1'b0, 1);
        chk("t3_hlen", meas_hlen, 100);
        chk("t3_act", meas_act, 50);

        // Frames of 525 short lines, vsync high for 3 lines starting on a rise.
        for (int i = 0; i < 1055; i++) line(8, 2, 3, 4, (i % 525) < 3, 1'b0, 0);
        chk("t4_lines", meas_lines, 525);
        chk("t4_vsw", meas_vsw, 3);

        // Randomized lines: mostly a stable period with occasional disturbances.
        base = $urandom_range(20, 60);
        for (int i = 0; i < 40; i++) begin
            p  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 60)) : base;
            w  = $urandom_range(1, p - 1);
            a0 = $urandom_range(0, p - 1);
            line(p, w, a0, $urandom_range(0, p - a0), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1));
        end

        // Lock, then hold hsync low past counter saturation.
        for (int i = 0; i < 7; i++) line(30, 4, 5, 10, 1'b0, 1'b0, 0);
        chk("t5_locked", locked, 1);
        line(65544, 8, 0, 0, 1'b0, 1'b0, 0);
        chk("t5_unlock", locked, 0);
        chk("t5_err", err, 1);
        line(30, 4, 5, 10, 1'b0, 1'b0, 0);
        chk("t5_no_stb_hlen", meas_hlen, 30);

        // Reset mid-line, relock, then break lock on the same tick as clr_err.
        do_reset();
        for (int i = 0; i < 7; i++) line(50, 6, 10, 20, 1'b0, 1'b0, 0);
        line(51, 6, 10, 20, 1'b0, 1'b0, 0);
        line(50, 6, 10, 20, 1'b0, 1'b1, 0);
        chk("t6_set_wins", err, 1);
        line(50, 6, 10, 20, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
